// File: rtl/led_pattern_engine_if.sv
// led_pattern_engine_if: control inputs and LED outputs of the pattern engine.
// The load/load_val pair exists only when LED_PATTERN_LOAD_EN is defined.
interface led_pattern_engine_if #(parameter int WIDTH = 16);
    logic             en;
    logic             dir;
    logic [1:0]       mode;
    logic [WIDTH-1:0] led;
    logic             tick;
    logic             wrap;
`ifdef LED_PATTERN_LOAD_EN
    logic             load;
    logic [WIDTH-1:0] load_val;
    modport master (output en, dir, mode, load, load_val, input led, tick, wrap);
    modport slave  (input en, dir, mode, load, load_val, output led, tick, wrap);
`else
    modport master (output en, dir, mode, input led, tick, wrap);
    modport slave  (input en, dir, mode, output led, tick, wrap);
`endif
endinterface

// File: rtl/led_pattern_engine.sv
// led_pattern_engine: rotate/bounce/fill/blink LED patterns stepped by a clock-enable prescaler.
// Optional feature macro LED_PATTERN_LOAD_EN adds a direct pattern load (load, load_val).
module led_pattern_engine #(
    parameter int WIDTH = 16,
    parameter int DIV   = 2**25
) (
    input logic                clk,
    input logic                rst,
    led_pattern_engine_if.slave bus
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0]    LAST = CW'(DIV - 1);
    localparam logic [WIDTH-1:0] MSB  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ONES = '1;
    localparam logic [1:0] ROTATE = 2'b00;
    localparam logic [1:0] BOUNCE = 2'b01;
    localparam logic [1:0] FILL   = 2'b10;

    typedef enum logic {PH_FILL, PH_DRAIN} phase_t;

    logic [WIDTH-1:0] led_q, led_d, fill_v, drain_v;
    logic [CW-1:0]    cnt;
    logic [1:0]       mode_q;
    logic             heading, heading_d, end_hit, one_hot;
    logic             tick_q, wrap_q, wrap_d, step;
    phase_t           phase, phase_d;

    assign bus.led  = led_q;
    assign bus.tick = tick_q;
    assign bus.wrap = wrap_q;

    // Next pattern, heading, fill/drain phase and wrap flag for a step in the current mode
    always_comb begin
        step      = bus.en && cnt == LAST;
        one_hot   = led_q != '0 && (led_q & (led_q - ONE)) == '0;
        end_hit   = heading ? led_q[WIDTH-1] : led_q[0];
        fill_v    = bus.dir ? ((led_q << 1) | ONE) : ((led_q >> 1) | MSB);
        drain_v   = bus.dir ? (led_q >> 1) : (led_q << 1);
        led_d     = led_q;
        heading_d = heading;
        phase_d   = phase;
        wrap_d    = 1'b0;
        case (mode_q)
            ROTATE: begin
                led_d  = !one_hot ? MSB :
                         bus.dir ? (led_q[WIDTH-1] ? ONE : led_q << 1) :
                                   (led_q[0] ? MSB : led_q >> 1);
                wrap_d = one_hot && (bus.dir ? led_q[WIDTH-1] : led_q[0]);
            end
            BOUNCE: begin
                heading_d = heading ^ end_hit;
                led_d     = heading_d ? led_q << 1 : led_q >> 1;
                wrap_d    = end_hit;
            end
            FILL: begin
                led_d   = phase == PH_FILL ? fill_v : drain_v;
                wrap_d  = phase == PH_FILL && fill_v == ONES;
                phase_d = phase == PH_FILL ? (fill_v == ONES ? PH_DRAIN : PH_FILL) :
                                             (drain_v == '0 ? PH_FILL : PH_DRAIN);
            end
            default: begin
                led_d  = ~led_q;
                wrap_d = led_q == '0;
            end
        endcase
    end

    // State register: reset > load > mode change > prescaler step
    always_ff @(posedge clk) begin
        if (rst) begin
            led_q   <= MSB;
            cnt     <= '0;
            tick_q  <= 1'b0;
            wrap_q  <= 1'b0;
            mode_q  <= ROTATE;
            heading <= bus.dir;
            phase   <= PH_FILL;
        end
`ifdef LED_PATTERN_LOAD_EN
        else if (bus.load) begin
            led_q  <= bus.load_val;
            cnt    <= '0;
            tick_q <= 1'b0;
            wrap_q <= 1'b0;
        end
`endif
        else if (bus.mode != mode_q) begin
            led_q   <= bus.mode[1] ? '0 : MSB;
            cnt     <= '0;
            tick_q  <= 1'b0;
            wrap_q  <= 1'b0;
            mode_q  <= bus.mode;
            heading <= bus.dir;
            phase   <= PH_FILL;
        end else begin
            cnt    <= !bus.en ? cnt : step ? '0 : cnt + 1'b1;
            tick_q <= step;
            wrap_q <= step && wrap_d;
            if (step) begin
                led_q   <= led_d;
                heading <= heading_d;
                phase   <= phase_d;
            end
        end
    end
endmodule

// File: tb/tb_led_pattern_engine.sv
// tb_led_pattern_engine: directed scoreboard bench for led_pattern_engine (WIDTH=8, DIV=4).
module tb_led_pattern_engine;
    localparam int WIDTH = 8;
    localparam int DIV   = 4;

    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;
    logic [7:0] cur;
    logic [9:0] exp_q[$];

    always #5 clk = ~clk;

    led_pattern_engine_if #(.WIDTH(WIDTH)) bus ();
    led_pattern_engine #(.WIDTH(WIDTH), .DIV(DIV)) dut (.clk(clk), .rst(rst), .bus(bus));

    task automatic expect_cycle(input string tag, input logic [7:0] l, input logic t, input logic w);
        logic [9:0] e;
        logic [9:0] o;
        exp_q.push_back({l, t, w});
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        o = {bus.led, bus.tick, bus.wrap};
        tests++;
        assert (o === e) else begin
            fails++;
            $error("FAIL %s: got led=%h tick=%b wrap=%b, expected led=%h tick=%b wrap=%b",
                   tag, o[9:2], o[1], o[0], e[9:2], e[1], e[0]);
        end
    endtask

    task automatic hold(input string tag, input int n);
        repeat (n) expect_cycle(tag, cur, 1'b0, 1'b0);
    endtask

    task automatic run_step(input string tag, input logic [7:0] l, input logic w);
        hold(tag, DIV - 1);
        expect_cycle(tag, l, 1'b1, w);
        cur = l;
    endtask

    task automatic enter(input string tag, input logic [1:0] m, input logic [7:0] start);
        bus.mode = m;
        expect_cycle(tag, start, 1'b0, 1'b0);
        cur = start;
    endtask

    initial begin
        logic [7:0] fill_seq [17];
        logic [7:0] bounce_seq [7];
        fill_seq   = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF, 8'h7F,
                       8'h3F, 8'h1F, 8'h0F, 8'h07, 8'h03, 8'h01, 8'h00, 8'h01};
        bounce_seq = '{8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};
        rst = 1'b1;
        bus.en = 1'b1;
        bus.dir = 1'b0;
        bus.mode = 2'b00;
`ifdef LED_PATTERN_LOAD_EN
        bus.load = 1'b0;
        bus.load_val = 8'h00;
`endif
        expect_cycle("reset", 8'h80, 1'b0, 1'b0);
        cur = 8'h80;
        rst = 1'b0;
        bus.dir = 1'b1;
        run_step("rot_left_wrap", 8'h01, 1'b1);
        run_step("rot_left", 8'h02, 1'b0);
        bus.dir = 1'b0;
        run_step("rot_right", 8'h01, 1'b0);
        run_step("rot_right_wrap", 8'h80, 1'b1);
        bus.dir = 1'b1;
        enter("bounce_entry", 2'b01, 8'h80);
        run_step("bounce_msb_reverse", 8'h40, 1'b1);
        bus.dir = 1'b0;
        for (int i = 0; i < 7; i++)
            run_step("bounce", bounce_seq[i], i == 6);
        bus.dir = 1'b1;
        enter("fill_entry", 2'b10, 8'h00);
        for (int i = 0; i < 17; i++)
            run_step("fill_drain", fill_seq[i], fill_seq[i] == 8'hFF);
        enter("blink_entry", 2'b11, 8'h00);
        run_step("blink_on", 8'hFF, 1'b1);
        run_step("blink_off", 8'h00, 1'b0);
        run_step("blink_on2", 8'hFF, 1'b1);
        hold("freeze_pre", 2);
        bus.en = 1'b0;
        hold("frozen", 10);
        bus.en = 1'b1;
        hold("resume", 1);
        expect_cycle("resume_step", 8'h00, 1'b1, 1'b0);
        cur = 8'h00;
        bus.en = 1'b0;
        enter("mode_chg_disabled", 2'b00, 8'h80);
        bus.en = 1'b1;
        hold("rot_count", 3);
        enter("mode_chg_over_step", 2'b10, 8'h00);
        run_step("fill_a", 8'h01, 1'b0);
        run_step("fill_b", 8'h03, 1'b0);
        run_step("fill_c", 8'h07, 1'b0);
        rst = 1'b1;
        bus.mode = 2'b00;
        expect_cycle("rst_mid_fill", 8'h80, 1'b0, 1'b0);
        cur = 8'h80;
        rst = 1'b0;
        run_step("rot_after_rst", 8'h01, 1'b1);
`ifdef LED_PATTERN_LOAD_EN
        bus.load = 1'b1;
        bus.load_val = 8'hA5;
        expect_cycle("load", 8'hA5, 1'b0, 1'b0);
        cur = 8'hA5;
        bus.load = 1'b0;
        run_step("load_rot_onehot", 8'h80, 1'b0);
        bus.load = 1'b1;
        bus.load_val = 8'h3C;
        bus.mode = 2'b11;
        expect_cycle("load_over_mode", 8'h3C, 1'b0, 1'b0);
        bus.load = 1'b0;
        expect_cycle("pending_mode", 8'h00, 1'b0, 1'b0);
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
